// File: rtl/adder_16bit_s.sv
// -----------------------------------------------------------------------------
// adder_16bit_s
//
// Registered 16-bit adder/subtractor with carry-out and two's-complement
// overflow flags. One operation is accepted on every rising clock edge and its
// result is visible on the outputs right after that same edge.
//
// Ports:
//   clk       in   1   clock, all state changes on the rising edge
//   rst       in   1   synchronous active-high reset (clears all outputs)
//   A         in  16   first operand (unsigned or two's-complement)
//   B         in  16   second operand (unsigned or two's-complement)
//   Add_ctrl  in   1   0 = A + B, 1 = A - B
//   SUM       out 16   registered result bits [15:0]
//   C_out     out  1   registered carry out of bit 15
//                      (in subtract mode: 1 = no borrow, 0 = borrow)
//   O         out  1   registered signed overflow flag
// -----------------------------------------------------------------------------
module adder_16bit_s (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Add_ctrl,
    output logic [15:0] SUM,
    output logic        C_out,
    output logic        O
);

    // Conditionally inverted second operand and carry-in. Subtraction is
    // A + ~B + 1, so one adder serves both modes.
    logic [15:0] bx;
    logic        c0;

    // Lower 15 bits are summed with one extra bit so that the carry into
    // bit 15 (c15) is available explicitly; the overflow flag needs it.
    logic [15:0] low_sum;
    logic        c15;
    logic        c16;

    logic [15:0] sum_d,   sum_q;
    logic        c_out_d, c_out_q;
    logic        o_d,     o_q;

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here is assigned unconditionally on every
        // pass, so no storage (latch) can be inferred for any of them.
        bx      = B ^ {16{Add_ctrl}};
        c0      = Add_ctrl;

        low_sum = {1'b0, A[14:0]} + {1'b0, bx[14:0]} + {15'd0, c0};
        c15     = low_sum[15];

        // Top bit handled as an explicit full adder to expose c16.
        c16     = (A[15] & bx[15]) | (c15 & (A[15] ^ bx[15]));

        sum_d   = {A[15] ^ bx[15] ^ c15, low_sum[14:0]};
        c_out_d = c16;
        // Signed overflow: carry into and out of the sign bit disagree.
        o_d     = c16 ^ c15;
    end

    // -------------------------------------------------------------------------
    // Output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge and wins over the operation
        // presented on that same edge; state uses non-blocking assignments so
        // every flop updates from values sampled before the edge.
        if (rst) begin
            sum_q   <= 16'h0000;
            c_out_q <= 1'b0;
            o_q     <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            o_q     <= o_d;
        end
    end

    // Outputs come straight from the flops: no input-to-output comb path.
    assign SUM   = sum_q;
    assign C_out = c_out_q;
    assign O     = o_q;

endmodule

// File: tb/tb_adder_16bit_s.sv
// -----------------------------------------------------------------------------
// tb_adder_16bit_s
//
// Directed checks of the registered adder/subtractor (reset, flag corner
// cases, reset priority, hold between edges) followed by a random sweep that
// compares every cycle against an arithmetic reference written in plain
// integer terms.
// -----------------------------------------------------------------------------
module tb_adder_16bit_s;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Add_ctrl;
    logic [15:0] SUM;
    logic        C_out;
    logic        O;

    int errors;
    int checks;

    adder_16bit_s dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .Add_ctrl (Add_ctrl),
        .SUM      (SUM),
        .C_out    (C_out),
        .O        (O)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic on unsigned and signed views of the
    // operands, returned as {O, C_out, SUM}.
    function automatic logic [17:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic        sub);
        int  ua;
        int  ub;
        int  sa;
        int  sb;
        int  ur;
        int  sr;
        logic c;
        logic o;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            c  = (ur > 65535);
        end
        o = (sr > 32767) || (sr < -32768);
        return {o, c, ur[15:0]};
    endfunction

    task automatic check(input string tag, input logic [17:0] exp);
        logic [17:0] obs;
        obs = {O, C_out, SUM};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed {O,C,SUM}=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present inputs, clock once, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [15:0] a,
                        input logic [15:0] b, input logic sub);
        rst      = r;
        A        = a;
        B        = b;
        Add_ctrl = sub;
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b1;
        A        = 16'h1234;
        B        = 16'hABCD;
        Add_ctrl = 1'b0;

        // Reset clears outputs regardless of operands.
        step(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        check("reset", 18'h0_0000);

        // Directed flag corner cases.
        step(1'b0, 16'h0001, 16'h0001, 1'b0);
        check("add_plain", {2'b00, 16'h0002});
        step(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        check("add_sovf", {2'b10, 16'h8000});
        step(1'b0, 16'hFFFF, 16'h0001, 1'b0);
        check("add_carry", {2'b01, 16'h0000});
        step(1'b0, 16'h8000, 16'h8000, 1'b0);
        check("add_negovf", {2'b11, 16'h0000});
        step(1'b0, 16'h1234, 16'h4321, 1'b0);
        check("add_mixed", {2'b00, 16'h5555});
        step(1'b0, 16'h0005, 16'h0003, 1'b1);
        check("sub_noborrow", {2'b01, 16'h0002});
        step(1'b0, 16'h0000, 16'h0001, 1'b1);
        check("sub_borrow", {2'b00, 16'hFFFF});
        step(1'b0, 16'h8000, 16'h0001, 1'b1);
        check("sub_sovf", {2'b11, 16'h7FFF});
        step(1'b0, 16'h1234, 16'h1234, 1'b1);
        check("sub_equal", {2'b01, 16'h0000});
        step(1'b0, 16'h7FFF, 16'hFFFF, 1'b1);
        check("sub_posovf", {2'b10, 16'h8000});

        // Inputs changing between edges must not disturb the held result.
        A        = 16'hFFFF;
        B        = 16'hFFFF;
        Add_ctrl = 1'b0;
        #3;
        check("hold", {2'b10, 16'h8000});

        // Reset mid-stream wins over the operation on the same edge, then
        // the very next edge registers the same inputs normally.
        step(1'b1, 16'h7FFF, 16'h0001, 1'b0);
        check("reset_prio", 18'h0_0000);
        step(1'b0, 16'h7FFF, 16'h0001, 1'b0);
        check("post_reset", {2'b10, 16'h8000});

        // Random regression, one result per cycle.
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom);
            step(1'b0, ra, rb, rs);
            check("random", model(ra, rb, rs));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
